// File: rtl/lb_scheduler.sv
// Credit-tracking dispatch stage: buffers request meta, tracks per-region outstanding
// requests and sends each request to the least-loaded eligible region (affinity, then round-robin).
module lb_scheduler #(
    parameter int N_REGIONS         = 4,
    parameter int HTTP_META_WIDTH   = 98,
    parameter int OPERATOR_ID_WIDTH = 16,
    parameter int QDEPTH            = 16,
    parameter int MAX_OUTSTANDING   = 15,
    parameter int AFFINITY          = 1,
    localparam int CW = $clog2(MAX_OUTSTANDING + 1),
    localparam int RW = $clog2(N_REGIONS),
    localparam int AW = $clog2(QDEPTH)
) (
    input  logic                                   aclk,
    input  logic                                   areset,
    input  logic                                   meta_in_tvalid,
    output logic                                   meta_in_tready,
    input  logic [HTTP_META_WIDTH-1:0]             meta_in_tdata,
    output logic                                   meta_out_tvalid,
    input  logic                                   meta_out_tready,
    output logic [HTTP_META_WIDTH-1:0]             meta_out_tdata,
    output logic [RW-1:0]                          meta_out_tdest,
    input  logic [N_REGIONS-1:0]                   region_en,
    input  logic [N_REGIONS*OPERATOR_ID_WIDTH-1:0] region_oid,
    input  logic [N_REGIONS-1:0]                   region_done,
    output logic [N_REGIONS*CW-1:0]                region_load,
    output logic [RW-1:0]                          lb_ctrl,
    output logic                                   err_underflow
);

    typedef enum logic [1:0] {IDLE = 2'd0, SELECT = 2'd1, SEND = 2'd2} state_t;

    state_t                       state_q, state_d;
    logic [HTTP_META_WIDTH-1:0]   fifo_mem [QDEPTH];
    logic [AW:0]                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                         fifo_empty, fifo_full, push, pop, dispatch;
    logic [HTTP_META_WIDTH-1:0]   hold_q, hold_d;
    logic [RW-1:0]                tdest_q, tdest_d, rr_q, rr_d, lb_q, lb_d;
    logic [CW-1:0]                load_q [N_REGIONS];
    logic [CW-1:0]                load_d [N_REGIONS];
    logic                         err_q, err_d;
    logic [N_REGIONS-1:0]         elig, cand, aff_match, pick_mask, load_inc, load_dec;
    logic [CW-1:0]                min_load;
    logic [RW-1:0]                pick, scan_idx;
    logic                         any_elig, pick_found;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign fifo_empty     = (wr_ptr_q == rd_ptr_q);
    assign fifo_full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign meta_in_tready = !fifo_full && !areset;
    assign push           = meta_in_tvalid && meta_in_tready;

    always_ff @(posedge aclk) begin
        if (push) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= meta_in_tdata;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!fifo_empty) state_d = SELECT;
            SELECT:  if (any_elig) state_d = SEND;
            SEND:    if (meta_out_tready) state_d = fifo_empty ? IDLE : SELECT;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        meta_out_tvalid = (state_q == SEND);
        dispatch        = (state_q == SEND) && meta_out_tready;
        pop             = !fifo_empty && ((state_q == IDLE) || dispatch);
    end

    // Region choice: minimum load, then operator affinity, then first index from rr_q.
    always_comb begin
        min_load  = CW'(MAX_OUTSTANDING);
        any_elig  = 1'b0;
        elig      = '0;
        cand      = '0;
        aff_match = '0;
        for (int r = 0; r < N_REGIONS; r++) begin
            elig[r] = region_en[r] && (load_q[r] < CW'(MAX_OUTSTANDING));
            if (elig[r]) begin
                any_elig = 1'b1;
                if (load_q[r] < min_load) min_load = load_q[r];
            end
        end
        for (int r = 0; r < N_REGIONS; r++) begin
            cand[r]      = elig[r] && (load_q[r] == min_load);
            aff_match[r] = cand[r] &&
                           (region_oid[r*OPERATOR_ID_WIDTH +: OPERATOR_ID_WIDTH] == hold_q[OPERATOR_ID_WIDTH-1:0]);
        end
        pick_mask  = ((AFFINITY != 0) && (|aff_match)) ? aff_match : cand;
        pick       = rr_q;
        pick_found = 1'b0;
        scan_idx   = rr_q;
        for (int k = 0; k < N_REGIONS; k++) begin
            scan_idx = rr_q + RW'(k);
            if (!pick_found && pick_mask[scan_idx]) begin
                pick       = scan_idx;
                pick_found = 1'b1;
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW+1)'(push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
        hold_d   = pop ? fifo_mem[rd_ptr_q[AW-1:0]] : hold_q;
        tdest_d  = ((state_q == SELECT) && any_elig) ? pick : tdest_q;
        rr_d     = rr_q;
        lb_d     = lb_q;
        if (dispatch) begin
            lb_d = tdest_q;
            rr_d = tdest_q + RW'(1);
        end
        err_d    = err_q;
        load_inc = '0;
        load_dec = '0;
        for (int r = 0; r < N_REGIONS; r++) begin
            load_inc[r] = dispatch && (tdest_q == RW'(r));
            load_dec[r] = region_done[r];
            load_d[r]   = load_q[r];
            if (load_inc[r] && !load_dec[r]) begin
                if (load_q[r] != CW'(MAX_OUTSTANDING)) load_d[r] = load_q[r] + CW'(1);
            end else if (load_dec[r] && !load_inc[r]) begin
                if (load_q[r] == '0) err_d = 1'b1;
                else load_d[r] = load_q[r] - CW'(1);
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            hold_q   <= '0;
            tdest_q  <= '0;
            rr_q     <= '0;
            lb_q     <= '0;
            err_q    <= 1'b0;
            for (int r = 0; r < N_REGIONS; r++) load_q[r] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            hold_q   <= hold_d;
            tdest_q  <= tdest_d;
            rr_q     <= rr_d;
            lb_q     <= lb_d;
            err_q    <= err_d;
            for (int r = 0; r < N_REGIONS; r++) load_q[r] <= load_d[r];
        end
    end

    assign meta_out_tdata = hold_q;
    assign meta_out_tdest = tdest_q;
    assign lb_ctrl        = lb_q;
    assign err_underflow  = err_q;

    for (genvar g = 0; g < N_REGIONS; g++) begin : g_load
        assign region_load[g*CW +: CW] = load_q[g];
    end

endmodule

// File: tb/tb_lb_scheduler.sv
// Self-checking bench for lb_scheduler: directed scenarios plus random traffic, checked by a
// scoreboard and a transaction-level model of loads, round-robin pointer and region choice.
module tb_lb_scheduler;

    localparam int N    = 4;
    localparam int W    = 98;
    localparam int OW   = 16;
    localparam int QD   = 16;
    localparam int MAXO = 3;
    localparam int AFF  = 1;
    localparam int CW   = $clog2(MAXO + 1);
    localparam int RW   = $clog2(N);

    logic            aclk = 1'b0;
    logic            areset = 1'b1;
    logic            meta_in_tvalid = 1'b0;
    logic            meta_in_tready;
    logic [W-1:0]    meta_in_tdata = '0;
    logic            meta_out_tvalid;
    logic            meta_out_tready = 1'b0;
    logic [W-1:0]    meta_out_tdata;
    logic [RW-1:0]   meta_out_tdest;
    logic [N-1:0]    region_en = '1;
    logic [N*OW-1:0] region_oid;
    logic [N-1:0]    region_done = '0;
    logic [N*CW-1:0] region_load;
    logic [RW-1:0]   lb_ctrl;
    logic            err_underflow;

    always #5 aclk = ~aclk;

    lb_scheduler #(
        .N_REGIONS(N), .HTTP_META_WIDTH(W), .OPERATOR_ID_WIDTH(OW),
        .QDEPTH(QD), .MAX_OUTSTANDING(MAXO), .AFFINITY(AFF)
    ) u_dut (
        .aclk(aclk), .areset(areset),
        .meta_in_tvalid(meta_in_tvalid), .meta_in_tready(meta_in_tready), .meta_in_tdata(meta_in_tdata),
        .meta_out_tvalid(meta_out_tvalid), .meta_out_tready(meta_out_tready),
        .meta_out_tdata(meta_out_tdata), .meta_out_tdest(meta_out_tdest),
        .region_en(region_en), .region_oid(region_oid), .region_done(region_done),
        .region_load(region_load), .lb_ctrl(lb_ctrl), .err_underflow(err_underflow)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [W-1:0] sb [$];
    int           obs_dest [$];
    int           obs_cyc [$];
    int           cyc_cnt = 0;

    int           mload [N];
    logic         merr = 1'b0;
    int           mlb = 0;
    int           mrr = 0;
    int           pend = -1;
    logic         prev_v = 1'b0;
    logic         prev_hs = 1'b0;
    logic [W-1:0] prev_data = '0;
    logic [RW-1:0] prev_dest = '0;

    logic [OW-1:0] oid_set [4] = '{16'h00AB, 16'h00CD, 16'h0011, 16'h0022};

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference choice from the selection rules, using the model's view of the loads.
    function automatic int pick_region(input logic [OW-1:0] roid);
        int  minl = 1 << 30;
        bit  have_aff = 1'b0;
        int  r;
        for (int i = 0; i < N; i++)
            if (region_en[i] && mload[i] < MAXO && mload[i] < minl) minl = mload[i];
        if (minl == (1 << 30)) return -1;
        for (int i = 0; i < N; i++)
            if (region_en[i] && mload[i] == minl && region_oid[i*OW +: OW] == roid) have_aff = (AFF != 0);
        for (int k = 0; k < N; k++) begin
            r = (mrr + k) % N;
            if (region_en[r] && mload[r] == minl && (!have_aff || region_oid[r*OW +: OW] == roid)) return r;
        end
        return -1;
    endfunction

    // Monitor: compares DUT state and outputs against the model once per cycle.
    always @(negedge aclk) begin
        logic         hs;
        logic [W-1:0] exp_d;
        logic [W-1:0] head;
        cyc_cnt++;
        if (areset) begin
            sb.delete();
            for (int r = 0; r < N; r++) mload[r] = 0;
            merr = 1'b0; mlb = 0; mrr = 0; pend = -1;
            prev_v = 1'b0; prev_hs = 1'b0;
        end else begin
            for (int r = 0; r < N; r++)
                chk($sformatf("region_load[%0d]", r), 128'(region_load[r*CW +: CW]), 128'(mload[r]));
            chk("err_underflow", 128'(err_underflow), 128'(merr));
            chk("lb_ctrl", 128'(lb_ctrl), 128'(mlb));
            hs = meta_out_tvalid && meta_out_tready;
            if (meta_out_tvalid) begin
                if (!prev_v || prev_hs) begin
                    chk("tdest_choice", 128'(meta_out_tdest), 128'(pend));
                end else begin
                    chk("tdata_stable", 128'(meta_out_tdata), 128'(prev_data));
                    chk("tdest_stable", 128'(meta_out_tdest), 128'(prev_dest));
                end
            end
            if (hs) begin
                chk("output_expected", 128'(sb.size() > 0), 128'(1));
                if (sb.size() > 0) begin
                    exp_d = sb.pop_front();
                    chk("tdata", 128'(meta_out_tdata), 128'(exp_d));
                end
                obs_dest.push_back(int'(meta_out_tdest));
                obs_cyc.push_back(cyc_cnt);
            end
            if (sb.size() > 0) begin
                head = sb[0];
                pend = pick_region(head[OW-1:0]);
            end else begin
                pend = -1;
            end
            for (int r = 0; r < N; r++) begin
                if (hs && meta_out_tdest == RW'(r) && !region_done[r]) begin
                    if (mload[r] < MAXO) mload[r]++;
                end else if (region_done[r] && !(hs && meta_out_tdest == RW'(r))) begin
                    if (mload[r] == 0) merr = 1'b1;
                    else mload[r]--;
                end
            end
            if (hs) begin
                mlb = int'(meta_out_tdest);
                mrr = (int'(meta_out_tdest) + 1) % N;
            end
            prev_v    = meta_out_tvalid;
            prev_hs   = hs;
            prev_data = meta_out_tdata;
            prev_dest = meta_out_tdest;
            if (meta_in_tvalid && meta_in_tready) sb.push_back(meta_in_tdata);
        end
    end

    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    task automatic push_req(input logic [OW-1:0] oid);
        logic [W-1:0] d;
        bit ok = 1'b0;
        d = W'({$urandom, $urandom, $urandom, $urandom});
        d[OW-1:0] = oid;
        meta_in_tdata  = d;
        meta_in_tvalid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge aclk);
            if (meta_in_tready) ok = 1'b1;
            cyc();
            if (ok) break;
        end
        meta_in_tvalid = 1'b0;
        chk("push_accepted", 128'(ok), 128'(1));
    endtask

    task automatic wait_out(input int n, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge aclk);
            if (obs_dest.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
        chk($sformatf("dispatch_count_%0d", n), 128'(ok), 128'(1));
        cyc();
    endtask

    task automatic do_reset();
        @(negedge aclk);
        #2;
        areset         = 1'b1;
        meta_in_tvalid = 1'b0;
        region_done    = '0;
        repeat (2) @(posedge aclk);
        #1;
        areset = 1'b0;
        obs_dest.delete();
        obs_cyc.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tvalid"}, 128'(meta_out_tvalid), 128'(0));
        chk({tag, "_tdest"}, 128'(meta_out_tdest), 128'(0));
        chk({tag, "_tdata"}, 128'(meta_out_tdata), 128'(0));
        chk({tag, "_lb_ctrl"}, 128'(lb_ctrl), 128'(0));
        chk({tag, "_load"}, 128'(region_load), 128'(0));
        chk({tag, "_err"}, 128'(err_underflow), 128'(0));
        chk({tag, "_tready"}, 128'(meta_in_tready), 128'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat;
        int  acc;
        bit  seen;
        logic [W-1:0] d;
        int  exp_seq [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

        for (int r = 0; r < N; r++) region_oid[r*OW +: OW] = 16'h1000 + 16'(r);
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk_reset_outputs("reset");
        cyc();
        areset = 1'b0;
        meta_out_tready = 1'b1;

        // Single request: latency 3 cycles and region 0.
        meta_in_tdata  = W'({$urandom, $urandom, $urandom, $urandom});
        meta_in_tdata[OW-1:0] = 16'h0055;
        meta_in_tvalid = 1'b1;
        @(negedge aclk);
        cyc();
        meta_in_tvalid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge aclk);
            if (meta_out_tvalid) begin
                lat = i;
                break;
            end
        end
        chk("latency", 128'(lat), 128'(3));
        chk("first_tdest", 128'(meta_out_tdest), 128'(0));
        cyc();
        @(negedge aclk);
        chk("first_lb_ctrl", 128'(lb_ctrl), 128'(0));
        chk("first_load0", 128'(region_load[0 +: CW]), 128'(1));
        cyc();

        // Back-to-back burst: round-robin order and one request every 2 cycles.
        for (int i = 0; i < 7; i++) push_req(16'h0055);
        wait_out(8, 60);
        for (int i = 0; i < 8; i++)
            chk($sformatf("rr_seq[%0d]", i), 128'(obs_dest[i]), 128'(exp_seq[i]));
        for (int i = 2; i < 8; i++)
            chk($sformatf("throughput[%0d]", i), 128'(obs_cyc[i] - obs_cyc[i-1]), 128'(2));
        chk("burst_loads", 128'(region_load), 128'({CW'(2), CW'(2), CW'(2), CW'(2)}));

        // Credit exhaustion: fill every region, next request must stall until a done pulse.
        for (int i = 0; i < 4; i++) push_req(16'h0055);
        wait_out(12, 60);
        push_req(16'h0022);
        repeat (10) cyc();
        @(negedge aclk);
        chk("stall_tvalid", 128'(meta_out_tvalid), 128'(0));
        cyc();
        region_done = 4'b1000;
        cyc();
        region_done = '0;
        wait_out(13, 20);
        chk("credit_tdest", 128'(obs_dest[12]), 128'(3));

        // Affinity: loads {1,0,0,1}, rr=1, region 2 holds the requested operator.
        do_reset();
        region_en = 4'b1000;
        push_req(16'h0055);
        wait_out(1, 20);
        region_en = 4'b0001;
        push_req(16'h0055);
        wait_out(2, 20);
        region_en = 4'b1111;
        region_oid[2*OW +: OW] = 16'h00AB;
        push_req(16'h00AB);
        wait_out(3, 20);
        chk("affinity_tdest", 128'(obs_dest[2]), 128'(2));

        // Done pulse coinciding with a dispatch to the same region.
        region_en = 4'b0010;
        push_req(16'h0011);
        wait_out(4, 20);
        meta_out_tready = 1'b0;
        push_req(16'h0011);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            if (meta_out_tvalid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("sim_tvalid_seen", 128'(seen), 128'(1));
        cyc();
        meta_out_tready = 1'b1;
        region_done = 4'b0010;
        cyc();
        region_done = '0;
        @(negedge aclk);
        chk("sim_load1", 128'(region_load[1*CW +: CW]), 128'(1));
        chk("sim_err", 128'(err_underflow), 128'(0));

        // Underflow on region 2 is sticky.
        cyc();
        region_done = 4'b0100;
        cyc();
        region_done = '0;
        @(negedge aclk);
        chk("uf_pre_load2", 128'(region_load[2*CW +: CW]), 128'(0));
        cyc();
        region_done = 4'b0100;
        cyc();
        region_done = '0;
        @(negedge aclk);
        chk("uf_load2", 128'(region_load[2*CW +: CW]), 128'(0));
        chk("uf_err", 128'(err_underflow), 128'(1));
        repeat (3) cyc();
        @(negedge aclk);
        chk("uf_err_sticky", 128'(err_underflow), 128'(1));
        cyc();

        // Back-pressure fills hold register plus FIFO, then asynchronous reset mid-stall.
        region_en = 4'b1111;
        meta_out_tready = 1'b0;
        acc = 0;
        for (int i = 0; i < 30; i++) begin
            d = W'({$urandom, $urandom, $urandom, $urandom});
            meta_in_tdata  = d;
            meta_in_tvalid = 1'b1;
            @(negedge aclk);
            if (meta_in_tready) acc++;
            cyc();
        end
        @(negedge aclk);
        chk("bp_accepted", 128'(acc), 128'(QD + 1));
        chk("bp_tready", 128'(meta_in_tready), 128'(0));
        chk("bp_tvalid", 128'(meta_out_tvalid), 128'(1));
        #2;
        areset = 1'b1;
        #1;
        chk_reset_outputs("midreset");
        meta_in_tvalid = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        areset = 1'b0;
        obs_dest.delete();
        obs_cyc.delete();
        meta_out_tready = 1'b1;
        repeat (6) cyc();
        @(negedge aclk);
        chk("post_reset_no_stale", 128'(obs_dest.size()), 128'(0));
        cyc();

        // Random traffic against the model.
        for (int r = 0; r < N; r++) region_oid[r*OW +: OW] = oid_set[r];
        for (int c = 0; c < 3000; c++) begin
            d = W'({$urandom, $urandom, $urandom, $urandom});
            d[OW-1:0] = oid_set[$urandom_range(0, 3)];
            meta_in_tdata   = d;
            meta_in_tvalid  = ($urandom_range(0, 1) == 1);
            meta_out_tready = ($urandom_range(0, 3) != 0);
            region_en       = 4'($urandom) | 4'($urandom);
            region_done     = 4'($urandom & $urandom);
            if ($urandom_range(0, 15) == 0)
                region_oid[$urandom_range(0, N-1)*OW +: OW] = oid_set[$urandom_range(0, 3)];
            cyc();
        end
        meta_in_tvalid  = 1'b0;
        meta_out_tready = 1'b1;
        region_en       = '1;
        for (int c = 0; c < 500; c++) begin
            region_done = 4'($urandom & $urandom);
            cyc();
            if (sb.size() == 0 && !meta_out_tvalid) break;
        end
        region_done = '0;
        repeat (2) cyc();
        @(negedge aclk);
        chk("drain_empty", 128'(sb.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
